// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------
// Generic valid/ready pipeline stage register carrying a PC+4 word and an
// instruction word. A second (skid) register absorbs the one entry that can
// arrive while the downstream is stalling. This lets in_ready be decoded purely
// from registered state, so there is no combinational path from out_ready to
// in_ready. A synchronous flush discards everything held plus the current
// offer, and the stage then presents a NOP bubble.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, the stall_cnt and flush_cnt performance counter ports exist.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   upstream offers an entry
//   in_ready   stage can accept (registered)
//   in_pc4     PC+4 of the offered entry
//   in_inst    instruction of the offered entry
//   flush      synchronous kill of held entries and of the current offer
//   out_valid  out_pc4/out_inst hold a valid entry
//   out_ready  downstream consumes the head entry
//   out_pc4    PC+4 of the head entry
//   out_inst   instruction of the head entry (NOP_INST when out_valid=0)
//   stall_cnt  cycles with out_valid & !out_ready & !flush (PIPE_STAGE_PERF_EN)
//   flush_cnt  cycles with flush while not EMPTY           (PIPE_STAGE_PERF_EN)

module pipe_stage_skid #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc4,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc4,
    output logic [INST_W-1:0] out_inst
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [PC_W-1:0]   main_pc4, main_pc4_next;
    logic [INST_W-1:0] main_inst, main_inst_next;
    logic [PC_W-1:0]   skid_pc4, skid_pc4_next;
    logic [INST_W-1:0] skid_inst, skid_inst_next;
    logic              in_fire;

    // Handshake decode. in_ready depends on registered state only.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready & ~flush;
    assign out_pc4   = main_pc4;
    assign out_inst  = main_inst;

    // State and data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            main_pc4  <= '0;
            main_inst <= NOP_INST;
            skid_pc4  <= '0;
            skid_inst <= NOP_INST;
        end else begin
            state     <= state_next;
            main_pc4  <= main_pc4_next;
            main_inst <= main_inst_next;
            skid_pc4  <= skid_pc4_next;
            skid_inst <= skid_inst_next;
        end
    end

    // Next-state and datapath steering. Every transition into EMPTY reloads
    // main with the bubble so out_inst reads NOP_INST whenever out_valid=0.
    always_comb begin
        state_next     = state;
        main_pc4_next  = main_pc4;
        main_inst_next = main_inst;
        skid_pc4_next  = skid_pc4;
        skid_inst_next = skid_inst;

        if (flush) begin
            state_next     = EMPTY;
            main_pc4_next  = '0;
            main_inst_next = NOP_INST;
            skid_pc4_next  = '0;
            skid_inst_next = NOP_INST;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next     = BUSY;
                        main_pc4_next  = in_pc4;
                        main_inst_next = in_inst;
                    end
                end
                BUSY: begin
                    if (in_fire && out_ready) begin
                        main_pc4_next  = in_pc4;
                        main_inst_next = in_inst;
                    end else if (in_fire) begin
                        state_next     = FULL;
                        skid_pc4_next  = in_pc4;
                        skid_inst_next = in_inst;
                    end else if (out_ready) begin
                        state_next     = EMPTY;
                        main_pc4_next  = '0;
                        main_inst_next = NOP_INST;
                    end
                end
                FULL: begin
                    // The skid entry was accepted after the head, so it moves
                    // up to the head when the head drains.
                    if (out_ready) begin
                        state_next     = BUSY;
                        main_pc4_next  = skid_pc4;
                        main_inst_next = skid_inst;
                        skid_pc4_next  = '0;
                        skid_inst_next = NOP_INST;
                    end
                end
                default: begin
                    state_next     = EMPTY;
                    main_pc4_next  = '0;
                    main_inst_next = NOP_INST;
                    skid_pc4_next  = '0;
                    skid_inst_next = NOP_INST;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Performance counters; both wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !flush) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (state != EMPTY)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
// ------------------
// Directed testbench for pipe_stage_skid. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled at the same point, so every sample
// reflects the state registered at the preceding edge.

module tb_pipe_stage_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc4;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checkCount = 0;
    int errorCount = 0;

    pipe_stage_skid #(
        .PC_W    (32),
        .INST_W  (32),
        .NOP_INST(NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc4   (in_pc4),
        .in_inst  (in_inst),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc4  (out_pc4),
        .out_inst (out_inst)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive all stage inputs; instruction is derived from pc4 so both fields are checked.
    task automatic applyStimulus(input logic v, input logic [31:0] pc4,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_pc4    = pc4;
        in_inst   = pc4 ^ 32'hABCD_0000;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    // Checks a valid head entry carrying pc4 (and its derived instruction).
    task automatic checkHead(input string tag, input logic [31:0] pc4);
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_pc4"}, out_pc4, pc4);
        checkOutput({tag, "_inst"}, out_inst, pc4 ^ 32'hABCD_0000);
    endtask

    // Checks the empty/bubble presentation.
    task automatic checkBubble(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_pc4"}, out_pc4, 32'd0);
        checkOutput({tag, "_inst"}, out_inst, NOP);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #2;
        // Reset state, before any clock edge
        checkBubble("reset");
        #9;
        rst = 1'b1;
        stepCycle();
        checkBubble("idle");

        // Streaming: one entry per cycle, no gaps
        applyStimulus(1'b1, 32'd4, 1'b1, 1'b0);
        stepCycle();
        checkHead("stream4", 32'd4);
        applyStimulus(1'b1, 32'd8, 1'b1, 1'b0);
        stepCycle();
        checkHead("stream8", 32'd8);
        checkOutput("stream8_in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 32'd12, 1'b1, 1'b0);
        stepCycle();
        checkHead("stream12", 32'd12);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        stepCycle();
        checkBubble("stream_drain");

        // Stall and skid
        applyStimulus(1'b1, 32'd4, 1'b0, 1'b0);
        stepCycle();
        checkHead("skid_first", 32'd4);
        checkOutput("skid_first_in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 32'd8, 1'b0, 1'b0);
        stepCycle();
        checkHead("skid_held", 32'd4);
        checkOutput("skid_full_in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b1, 32'd12, 1'b0, 1'b0);
        stepCycle();
        checkHead("skid_ignore12", 32'd4);
        checkOutput("skid_ignore12_in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        stepCycle();
        checkHead("skid_release8", 32'd8);
        checkOutput("skid_release_in_ready", {31'd0, in_ready}, 32'd1);
        stepCycle();
        checkBubble("skid_done");

        // Flush while FULL with an offer present
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
        stepCycle();
        checkOutput("flush_pre_in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b1, 32'h18, 1'b1, 1'b1);
        stepCycle();
        checkBubble("flush_full");
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("flush_cnt_one", flush_cnt, 32'd1);
`endif
        // Flush while EMPTY with in_ready=1: offer still dropped
        applyStimulus(1'b1, 32'h1C, 1'b1, 1'b1);
        stepCycle();
        checkBubble("flush_empty");
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        stepCycle();
        checkBubble("flush_nothing_leaks");
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("flush_cnt_empty", flush_cnt, 32'd1);
`endif

        // Asynchronous reset in the middle of a FULL stall
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'h24, 1'b0, 1'b0);
        stepCycle();
        checkHead("areset_pre", 32'h20);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        checkBubble("areset_now");
        #2;
        rst = 1'b1;
        stepCycle();
        checkBubble("areset_idle");
        applyStimulus(1'b1, 32'h30, 1'b1, 1'b0);
        stepCycle();
        checkHead("areset_first", 32'h30);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        stepCycle();
        checkBubble("areset_alone");

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter: five stalled cycles, then wrap from all-ones
        rst = 1'b0;
        #1;
        rst = 1'b1;
        checkOutput("stall_cnt_reset", stall_cnt, 32'd0);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
        end
        checkOutput("stall_cnt_five", stall_cnt, 32'd5);
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        stepCycle();
        checkOutput("stall_cnt_wrap", stall_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised valid/ready pipeline stage register for the static-pipeline CPU. It replaces the fixed IF/ID latch with a generic stage that carries a PC+4 word and an instruction word, and adds a two-entry skid buffer so the upstream ready is registered. It also adds a synchronous flush that inserts a NOP bubble. One instance sits between each pair of pipeline stages; IF/ID is the first user.

## Interface
Parameters:
- PC_W, 32, width of the PC+4 field
- INST_W, 32, width of the instruction field
- NOP_INST, 32'h00000000, instruction value presented while the stage holds no valid entry

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream offers an entry
- in_ready  output  1  stage can accept; registered
- in_pc4  input  PC_W  PC+4 of offered entry
- in_inst  input  INST_W  instruction of offered entry
- flush  input  1  synchronous kill of all held entries and of the current offer
- out_valid  output  1  out_pc4/out_inst hold a valid entry
- out_ready  input  1  downstream consumes (the old nostall)
- out_pc4  output  PC_W  PC+4 of head entry
- out_inst  output  INST_W  instruction of head entry
- stall_cnt  output  32  only with PIPE_STAGE_PERF_EN
- flush_cnt  output  32  only with PIPE_STAGE_PERF_EN

## Operation
- Storage:
  - main register: drives out_*.
  - skid register: holds one extra entry.
  - 2-bit state: EMPTY, BUSY (main valid), FULL (main and skid valid).
- Handshakes:
  - in_fire = in_valid & in_ready & !flush.
  - out_fire = out_valid & out_ready.
- Outputs:
  - in_ready = (state != FULL), decoded from registered state only.
  - out_valid = (state != EMPTY).
- EMPTY:
  - in_fire loads main from input and moves to BUSY.
  - Otherwise stays EMPTY.
- BUSY:
  - in_fire & out_ready: main loads input; stay BUSY.
  - in_fire & !out_ready: skid loads input; go to FULL.
  - !in_fire & out_ready: go to EMPTY.
  - Neither: hold.
- FULL (in_ready=0, inputs ignored):
  - out_ready: main loads skid; go to BUSY.
  - Otherwise hold.
- Flush:
  - Highest priority. From any state, the next state is EMPTY.
  - The offered entry is dropped, even with in_valid=1 and in_ready=1.
  - out_ready in the flush cycle has no effect on state.
- Bubble: every entry into EMPTY (reset, flush, drain) loads main with pc4=0 and inst=NOP_INST. out_inst therefore equals NOP_INST whenever out_valid=0.
- Ordering: entries leave in acceptance order. No duplication, no loss except on flush.

## Timing
- Reset values:
  - state EMPTY, in_ready=1, out_valid=0.
  - out_pc4=0, out_inst=NOP_INST, skid cleared to 0/NOP_INST.
  - counters 0.
- Reset mid-operation clears everything asynchronously and discards held entries.
- Latency:
  - Accepted input appears on out_* the next cycle when the stage was EMPTY, or when BUSY with out_ready=1.
  - Otherwise it appears after the head entry drains.
- Throughput: 1 entry/cycle with out_ready held high.
- Stall response:
  - in_ready falls one cycle after the first stalled cycle that accepted an entry into the skid.
  - No combinational path from out_ready to in_ready.
- FULL exit: in_ready rises the cycle after out_fire in FULL.
- Flush timing: out_valid=0 the cycle after flush is sampled high; in_ready=1 that same cycle.

## Configuration
- PIPE_STAGE_PERF_EN defined:
  - stall_cnt increments every cycle with out_valid=1 & out_ready=0 & flush=0.
  - flush_cnt increments every cycle flush=1 while state != EMPTY.
  - Both are 32-bit, wrap to 0 after 32'hFFFFFFFF, and reset to 0.
- Not defined: both ports and their counters are absent. Datapath behaviour is identical.

## Test plan
- Reset then idle: rst low then high, in_valid=0 -> out_valid=0, out_inst=NOP_INST, out_pc4=0, in_ready=1.
- Streaming: in_valid=1 with pc4=4,8,12 on consecutive cycles, out_ready=1 -> out_pc4 equals 4,8,12 one cycle later each, with no gaps.
- Stall/skid:
  - Stimulus: accept pc4=4, then pc4=8 while out_ready=0.
  - Required: out_pc4 stays 4, in_ready=0 next cycle, and pc4=12 offered meanwhile is not accepted.
  - Release: out_ready=1 gives 4 then 8, then in_ready returns to 1.
- Flush in FULL with in_valid=1: next cycle out_valid=0, out_inst=NOP_INST, and neither held entry nor the offer ever appears. With PIPE_STAGE_PERF_EN, flush_cnt=1.
- Async reset asserted mid-stall in FULL, not aligned to clk: outputs return to reset values immediately. After release, the first accepted entry appears alone.
- PIPE_STAGE_PERF_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5. Preload stall_cnt to 32'hFFFFFFFF (force) plus one stall cycle -> stall_cnt=0.
